// File: rtl/mmu_pkg.sv
// Shared MMU types and constants used by the page-table walker and its bench.
package mmu_pkg;

    localparam int PAGE_SHIFT       = 12;
    localparam int PTE_BYTES        = 8;
    localparam int PTE_VALID_BIT    = 0;
    localparam int IDX_WIDTH        = 12;
    localparam int WALK_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L2_REQ,
        L2_WAIT,
        RESP,
        DRAIN
    } ptw_state_e;

    // Layout for the default 64-bit PTE with a 24-bit PPN.
    typedef struct packed {
        logic [27:0] rsvd;
        logic [23:0] ppn;
        logic [10:0] flags;
        logic        valid;
    } pte_t;

endpackage

// File: rtl/page_table_walker.sv
// Two-level hardware page-table walker refilling the upstream TLB through a
// single-outstanding PTE read port.
module page_table_walker
    import mmu_pkg::*;
#(
    parameter int VPN_WIDTH  = 24,
    parameter int PPN_WIDTH  = 24,
    parameter int ADDR_WIDTH = 48,
    parameter int PTE_WIDTH  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       ptbr,
    input  logic                        miss_valid,
    output logic                        miss_ready,
    input  logic [VPN_WIDTH-1:0]        miss_vpn,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    input  logic                        mem_rsp_valid,
    input  logic [PTE_WIDTH-1:0]        mem_rsp_data,
    output logic                        refill_valid,
    input  logic                        refill_ready,
    output logic [VPN_WIDTH-1:0]        refill_vpn,
    output logic [PPN_WIDTH-1:0]        refill_ppn,
    output logic                        refill_fault,
    input  logic                        flush,
    output logic [WALK_COUNT_WIDTH-1:0] walk_count
);

    localparam int PTE_SHIFT = $clog2(PTE_BYTES);

    ptw_state_e                  state_q, state_d;
    logic [VPN_WIDTH-1:0]        vpn_q, vpn_d;
    logic [PPN_WIDTH-1:0]        ppn_q, ppn_d;
    logic                        fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]       req_addr_q, req_addr_d;
    logic [WALK_COUNT_WIDTH-1:0] walk_count_q, walk_count_d;

    logic [IDX_WIDTH-1:0]  idx1;
    logic [IDX_WIDTH-1:0]  idx0;
    logic [ADDR_WIDTH-1:0] l1_addr;
    logic [ADDR_WIDTH-1:0] l2_addr;
    logic                  pte_valid;
    logic [PPN_WIDTH-1:0]  pte_ppn;
    logic                  miss_take;
    logic                  rsp_take;
    logic                  unused_rsp_bits;

    // Level-1 index comes straight from the incoming miss; level-2 index from the held VPN.
    assign idx1 = miss_vpn[2*IDX_WIDTH-1:IDX_WIDTH];
    assign idx0 = vpn_q[IDX_WIDTH-1:0];

    assign pte_valid = mem_rsp_data[PTE_VALID_BIT];
    assign pte_ppn   = mem_rsp_data[PPN_WIDTH+PAGE_SHIFT-1:PAGE_SHIFT];

    assign unused_rsp_bits = ^{mem_rsp_data[PTE_WIDTH-1:PPN_WIDTH+PAGE_SHIFT],
                               mem_rsp_data[PAGE_SHIFT-1:PTE_VALID_BIT+1]};

    // Sums wrap silently at ADDR_WIDTH.
    assign l1_addr = ptbr + (ADDR_WIDTH'(idx1) << PTE_SHIFT);
    assign l2_addr = (ADDR_WIDTH'(pte_ppn) << PAGE_SHIFT) + (ADDR_WIDTH'(idx0) << PTE_SHIFT);

    // flush outranks every handshake that could advance the walk.
    assign miss_take = miss_valid && !flush;
    assign rsp_take  = mem_rsp_valid && !flush;

    // NOTE: rst_n is sampled only at the clock edge, so it is timed like any other data input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: flops always take <= so every register sees pre-edge values of the others.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of latches.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (miss_take) state_d = L1_REQ;
            end
            L1_REQ: begin
                if (flush)              state_d = IDLE;
                else if (mem_req_ready) state_d = L1_WAIT;
            end
            L1_WAIT: begin
                if (flush)         state_d = DRAIN;
                else if (rsp_take) state_d = pte_valid ? L2_REQ : RESP;
            end
            L2_REQ: begin
                if (flush)              state_d = IDLE;
                else if (mem_req_ready) state_d = L2_WAIT;
            end
            L2_WAIT: begin
                if (flush)         state_d = DRAIN;
                else if (rsp_take) state_d = RESP;
            end
            RESP: begin
                if (flush || refill_ready) state_d = IDLE;
            end
            DRAIN: begin
                if (mem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        refill_valid  = 1'b0;
        unique case (state_q)
            IDLE:           miss_ready    = 1'b1;
            L1_REQ, L2_REQ: mem_req_valid = 1'b1;
            RESP:           refill_valid  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        vpn_d        = vpn_q;
        ppn_d        = ppn_q;
        fault_d      = fault_q;
        req_addr_d   = req_addr_q;
        walk_count_d = walk_count_q;
        unique case (state_q)
            IDLE: begin
                if (miss_take) begin
                    vpn_d      = miss_vpn;
                    ppn_d      = '0;
                    fault_d    = 1'b0;
                    req_addr_d = l1_addr;
                end
            end
            L1_WAIT: begin
                if (rsp_take) begin
                    if (pte_valid) begin
                        ppn_d      = pte_ppn;
                        req_addr_d = l2_addr;
                    end else begin
                        ppn_d   = '0;
                        fault_d = 1'b1;
                    end
                end
            end
            L2_WAIT: begin
                if (rsp_take) begin
                    ppn_d   = pte_valid ? pte_ppn : '0;
                    fault_d = !pte_valid;
                end
            end
            RESP: begin
                if (!flush && refill_ready) walk_count_d = walk_count_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpn_q        <= '0;
            ppn_q        <= '0;
            fault_q      <= 1'b0;
            req_addr_q   <= '0;
            walk_count_q <= '0;
        end else begin
            vpn_q        <= vpn_d;
            ppn_q        <= ppn_d;
            fault_q      <= fault_d;
            req_addr_q   <= req_addr_d;
            walk_count_q <= walk_count_d;
        end
    end

    assign mem_req_addr = req_addr_q;
    assign refill_vpn   = vpn_q;
    assign refill_ppn   = ppn_q;
    assign refill_fault = fault_q;
    assign walk_count   = walk_count_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: a PTE memory driven inline and a refill scoreboard.
module tb_page_table_walker;
    import mmu_pkg::*;

    localparam int VW         = 24;
    localparam int PW         = 24;
    localparam int AW         = 48;
    localparam int TW         = 64;
    localparam int WAIT_LIMIT = 32;

    typedef struct packed {
        logic [VW-1:0] vpn;
        logic [PW-1:0] ppn;
        logic          fault;
    } refill_t;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic [AW-1:0] ptbr          = '0;
    logic          miss_valid    = 1'b0;
    logic [VW-1:0] miss_vpn      = '0;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [TW-1:0] mem_rsp_data  = '0;
    logic          refill_ready  = 1'b0;
    logic          flush         = 1'b0;

    logic          miss_ready;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          refill_valid;
    logic [VW-1:0] refill_vpn;
    logic [PW-1:0] refill_ppn;
    logic          refill_fault;
    logic [15:0]   walk_count;

    page_table_walker #(
        .VPN_WIDTH (VW),
        .PPN_WIDTH (PW),
        .ADDR_WIDTH(AW),
        .PTE_WIDTH (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ptbr         (ptbr),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_vpn     (miss_vpn),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .refill_valid (refill_valid),
        .refill_ready (refill_ready),
        .refill_vpn   (refill_vpn),
        .refill_ppn   (refill_ppn),
        .refill_fault (refill_fault),
        .flush        (flush),
        .walk_count   (walk_count)
    );

    always #5 clk = ~clk;

    int cyc       = 0;
    int req_fires = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && mem_req_valid && mem_req_ready) req_fires <= req_fires + 1;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          t_miss   = 0;
    logic [15:0] exp_walks;
    refill_t     exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "simulation timeout");
    end

    function automatic logic [AW-1:0] l1_addr_of(input logic [AW-1:0] base, input logic [VW-1:0] vpn);
        return base + AW'(vpn[23:12]) * AW'(PTE_BYTES);
    endfunction

    function automatic logic [AW-1:0] l2_addr_of(input logic [PW-1:0] ppn, input logic [VW-1:0] vpn);
        return AW'(ppn) * 48'd4096 + AW'(vpn[11:0]) * AW'(PTE_BYTES);
    endfunction

    // Ignored PTE fields are filled with noise so the walker must mask them.
    function automatic logic [TW-1:0] make_pte(input logic [PW-1:0] ppn, input logic valid);
        pte_t p;
        p.rsvd  = 28'($urandom);
        p.ppn   = ppn;
        p.flags = 11'($urandom);
        p.valid = valid;
        return p;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_miss_ready"},    64'(miss_ready),    64'd1);
        check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_mem_req_addr"},  64'(mem_req_addr),  64'd0);
        check({tag, "_refill_valid"},  64'(refill_valid),  64'd0);
        check({tag, "_refill_vpn"},    64'(refill_vpn),    64'd0);
        check({tag, "_refill_ppn"},    64'(refill_ppn),    64'd0);
        check({tag, "_refill_fault"},  64'(refill_fault),  64'd0);
        check({tag, "_walk_count"},    64'(walk_count),    64'd0);
    endtask

    task automatic send_miss(input string tag, input logic [VW-1:0] vpn, input logic [AW-1:0] base);
        int n = 0;
        while (miss_ready !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_miss_ready"}, 64'(miss_ready), 64'd1);
        miss_valid = 1'b1;
        miss_vpn   = vpn;
        ptbr       = base;
        t_miss     = cyc;
        tick();
        miss_valid = 1'b0;
        miss_vpn   = 24'h5A5A5A;
        ptbr       = 48'hFFFF_0000_1238;
    endtask

    task automatic serve_req(input string tag, input logic [AW-1:0] exp_addr, input int stall);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
        check({tag, "_req_addr"},  64'(mem_req_addr),  64'(exp_addr));
        repeat (stall) begin
            tick();
            check({tag, "_stall_valid"}, 64'(mem_req_valid), 64'd1);
            check({tag, "_stall_addr"},  64'(mem_req_addr),  64'(exp_addr));
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check({tag, "_req_dropped"}, 64'(mem_req_valid), 64'd0);
    endtask

    task automatic give_rsp(input logic [TW-1:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = {$urandom, $urandom};
    endtask

    task automatic wait_refill(input string tag);
        int n = 0;
        while (refill_valid !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_refill_valid"}, 64'(refill_valid), 64'd1);
    endtask

    task automatic compare_refill(input string tag, input int exp_lat, output refill_t got);
        refill_t e = '0;
        check({tag, "_latency"},  64'(cyc - t_miss), 64'(exp_lat));
        check({tag, "_sb_avail"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check({tag, "_vpn"},   64'(refill_vpn),   64'(e.vpn));
        check({tag, "_ppn"},   64'(refill_ppn),   64'(e.ppn));
        check({tag, "_fault"}, 64'(refill_fault), 64'(e.fault));
        got = e;
    endtask

    task automatic release_refill(input string tag, input int stall, input refill_t e);
        repeat (stall) begin
            tick();
            check({tag, "_hold_valid"}, 64'(refill_valid), 64'd1);
            check({tag, "_hold_vpn"},   64'(refill_vpn),   64'(e.vpn));
            check({tag, "_hold_ppn"},   64'(refill_ppn),   64'(e.ppn));
            check({tag, "_hold_fault"}, 64'(refill_fault), 64'(e.fault));
        end
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
        exp_walks    = exp_walks + 16'd1;
        check({tag, "_refill_done"}, 64'(refill_valid), 64'd0);
        check({tag, "_walk_count"},  64'(walk_count),   64'(exp_walks));
    endtask

    task automatic do_walk(input string tag, input logic [VW-1:0] vpn, input logic [AW-1:0] base,
                           input logic [TW-1:0] l1_pte, input logic [TW-1:0] l2_pte,
                           input int s_req, input int s_rsp);
        refill_t e;
        refill_t got;
        int      r0;
        logic    l1v;
        l1v     = l1_pte[0];
        e.vpn   = vpn;
        e.fault = !l1v || !l2_pte[0];
        e.ppn   = e.fault ? '0 : l2_pte[35:12];
        exp_q.push_back(e);
        r0 = req_fires;
        send_miss(tag, vpn, base);
        serve_req({tag, "_l1"}, l1_addr_of(base, vpn), s_req);
        give_rsp(l1_pte);
        if (l1v) begin
            serve_req({tag, "_l2"}, l2_addr_of(l1_pte[35:12], vpn), s_req);
            give_rsp(l2_pte);
        end
        wait_refill(tag);
        compare_refill(tag, l1v ? 5 + 2 * s_req : 3 + s_req, got);
        release_refill(tag, s_rsp, got);
        check({tag, "_req_count"}, 64'(req_fires - r0), l1v ? 64'd2 : 64'd1);
    endtask

    initial begin
        refill_t     e;
        refill_t     got;
        logic [TW-1:0] l1p;

        exp_walks = '0;
        repeat (3) tick();
        check_idle_reset("reset");
        rst_n = 1'b1;
        tick();
        check_idle_reset("post_reset");

        // Reference walk with hand-computed addresses and result.
        e = '{vpn: 24'h00A005, ppn: 24'h0ABCDE, fault: 1'b0};
        exp_q.push_back(e);
        send_miss("basic", 24'h00A005, 48'h1000_0000);
        serve_req("basic_l1", 48'h1000_0050, 0);
        give_rsp(64'h0020_0001);
        serve_req("basic_l2", 48'h0020_0028, 0);
        give_rsp(64'hABCD_E001);
        wait_refill("basic");
        compare_refill("basic", 5, got);
        release_refill("basic", 0, got);

        do_walk("l1_fault", 24'h3FF123, 48'h2000_8000, 64'h0, make_pte(24'h111111, 1'b1), 0, 0);
        do_walk("l2_fault", 24'h800FFF, 48'h0000_0000, make_pte(24'h000457, 1'b1),
                make_pte(24'h222222, 1'b0), 0, 0);
        do_walk("backpressure", 24'hFFFFFF, 48'hFFFF_FFFF_8000, make_pte(24'hFFFFFF, 1'b1),
                make_pte(24'h123456, 1'b1), 3, 4);

        // A miss arriving together with flush in IDLE is dropped.
        miss_valid = 1'b1;
        miss_vpn   = 24'h000001;
        flush      = 1'b1;
        tick();
        miss_valid = 1'b0;
        flush      = 1'b0;
        check("flush_idle_ready", 64'(miss_ready),    64'd1);
        check("flush_idle_noreq", 64'(mem_req_valid), 64'd0);

        // flush beats a simultaneous mem_req_ready in L1_REQ.
        send_miss("flush_l1req", 24'h123123, 48'h0040_0000);
        check("flush_l1req_valid", 64'(mem_req_valid), 64'd1);
        flush         = 1'b1;
        mem_req_ready = 1'b1;
        tick();
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        check("flush_l1req_idle",  64'(miss_ready),    64'd1);
        check("flush_l1req_noreq", 64'(mem_req_valid), 64'd0);
        check("flush_l1req_count", 64'(walk_count),    64'(exp_walks));

        // flush in L2_WAIT drains the outstanding response before going idle.
        send_miss("flush_wait", 24'h456789, 48'h0080_0000);
        serve_req("flush_wait_l1", l1_addr_of(48'h0080_0000, 24'h456789), 0);
        give_rsp(make_pte(24'h000ABC, 1'b1));
        serve_req("flush_wait_l2", l2_addr_of(24'h000ABC, 24'h456789), 0);
        flush = 1'b1;
        tick();
        check("drain_ready0",  64'(miss_ready),    64'd0);
        check("drain_noreq",   64'(mem_req_valid), 64'd0);
        check("drain_norefill", 64'(refill_valid), 64'd0);
        tick();
        flush = 1'b0;
        check("drain_ready1", 64'(miss_ready), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = make_pte(24'h999999, 1'b1);
        check("drain_rsp_cycle_ready", 64'(miss_ready), 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        check("drain_done_ready",    64'(miss_ready),   64'd1);
        check("drain_done_norefill", 64'(refill_valid), 64'd0);
        check("drain_done_count",    64'(walk_count),   64'(exp_walks));
        do_walk("after_flush", 24'h00C0DE, 48'h0100_0000, make_pte(24'h0F0F0F, 1'b1),
                make_pte(24'h765432, 1'b1), 0, 1);

        // flush in RESP discards the refill without counting it.
        send_miss("flush_resp", 24'h777000, 48'h0200_0000);
        serve_req("flush_resp_l1", l1_addr_of(48'h0200_0000, 24'h777000), 0);
        give_rsp(make_pte(24'h000001, 1'b0));
        wait_refill("flush_resp");
        flush        = 1'b1;
        refill_ready = 1'b1;
        tick();
        flush        = 1'b0;
        refill_ready = 1'b0;
        check("flush_resp_gone",  64'(refill_valid), 64'd0);
        check("flush_resp_idle",  64'(miss_ready),   64'd1);
        check("flush_resp_count", 64'(walk_count),   64'(exp_walks));

        // Stray response in IDLE, then a miss held high during RESP.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = make_pte(24'h333333, 1'b1);
        tick();
        mem_rsp_valid = 1'b0;
        check("stray_idle_ready", 64'(miss_ready),    64'd1);
        check("stray_idle_noreq", 64'(mem_req_valid), 64'd0);
        e = '{vpn: 24'h0AB0CD, ppn: 24'h55AA55, fault: 1'b0};
        exp_q.push_back(e);
        send_miss("held_a", 24'h0AB0CD, 48'h0300_0000);
        l1p = make_pte(24'h0000F0, 1'b1);
        serve_req("held_a_l1", l1_addr_of(48'h0300_0000, 24'h0AB0CD), 0);
        give_rsp(l1p);
        serve_req("held_a_l2", l2_addr_of(24'h0000F0, 24'h0AB0CD), 0);
        give_rsp(make_pte(24'h55AA55, 1'b1));
        wait_refill("held_a");
        compare_refill("held_a", 5, got);
        miss_valid = 1'b1;
        miss_vpn   = 24'h0FEDCB;
        ptbr       = 48'h0400_0000;
        repeat (2) begin
            tick();
            check("held_resp_valid", 64'(refill_valid), 64'd1);
            check("held_resp_vpn",   64'(refill_vpn),   64'(got.vpn));
            check("held_not_ready",  64'(miss_ready),   64'd0);
        end
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
        exp_walks    = exp_walks + 16'd1;
        check("held_a_count",  64'(walk_count), 64'(exp_walks));
        check("held_b_ready",  64'(miss_ready), 64'd1);
        e = '{vpn: 24'h0FEDCB, ppn: 24'h010203, fault: 1'b0};
        exp_q.push_back(e);
        t_miss = cyc;
        tick();
        miss_valid = 1'b0;
        serve_req("held_b_l1", l1_addr_of(48'h0400_0000, 24'h0FEDCB), 0);
        give_rsp(make_pte(24'h00ABCD, 1'b1));
        serve_req("held_b_l2", l2_addr_of(24'h00ABCD, 24'h0FEDCB), 0);
        give_rsp(make_pte(24'h010203, 1'b1));
        wait_refill("held_b");
        compare_refill("held_b", 5, got);
        release_refill("held_b", 0, got);

        // Counter wrap: preload to all-ones, one more walk must land on zero.
        force dut.walk_count_q = 16'hFFFF;
        #1;
        release dut.walk_count_q;
        exp_walks = 16'hFFFF;
        check("wrap_preload", 64'(walk_count), 64'hFFFF);
        do_walk("wrap", 24'h1F2E3D, 48'h0500_0000, 64'h0, 64'h0, 0, 0);
        check("wrap_zero", 64'(walk_count), 64'd0);

        // Reset in the middle of L1_WAIT, then a late response that must be ignored.
        send_miss("mid_rst", 24'h2468AC, 48'h0600_0000);
        serve_req("mid_rst_l1", l1_addr_of(48'h0600_0000, 24'h2468AC), 0);
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        exp_walks = '0;
        check_idle_reset("mid_rst");
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = make_pte(24'h13579B, 1'b1);
        tick();
        mem_rsp_valid = 1'b0;
        check_idle_reset("mid_rst_stray");
        do_walk("after_rst", 24'h00F00F, 48'h0700_8000, make_pte(24'h0C0C0C, 1'b1),
                make_pte(24'h0D0D0D, 1'b1), 1, 0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
